// File: rtl/crc7_arbiter_if.sv
// Bundle of requester and engine signals shared by the CRC-7 arbiter and its environment.
// The arbiter uses the slave view; the requesters and the engine model use the master view.
interface crc7_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic        ack0;
  logic        ack1;
  logic [6:0]  crc_out;
  logic        err;
  logic        busy;
  logic [31:0] eng_data;
  logic        eng_start;
  logic [7:0]  eng_crc;
  logic        eng_done;

  modport slave (
    input  req0, req1, data0, data1, eng_crc, eng_done,
    output gnt0, gnt1, ack0, ack1, crc_out, err, busy, eng_data, eng_start
  );

  modport master (
    output req0, req1, data0, data1, eng_crc, eng_done,
    input  gnt0, gnt1, ack0, ack1, crc_out, err, busy, eng_data, eng_start
  );
endinterface

// File: rtl/crc7_arbiter.sv
// Two-requester arbiter in front of a single CRC-7 engine: alternating priority on contention,
// one operation at a time, with a bounded wait on the engine's completion flag.
module crc7_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  crc7_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        lp_q, lp_d;
  logic        own_q, own_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  crc_q, crc_d;
  logic        to_q, to_d;
  logic        sel;
  logic        unused_crc_msb;

  assign unused_crc_msb = arb.eng_crc[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lp_q    <= 1'b1;
      own_q   <= 1'b0;
      timer_q <= '0;
      data_q  <= '0;
      crc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      own_q   <= own_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    own_d   = own_q;
    timer_d = timer_q;
    data_d  = data_q;
    crc_d   = crc_q;
    to_d    = to_q;
    sel     = (arb.req0 & arb.req1) ? ~lp_q : arb.req1;
    unique case (state_q)
      IDLE: begin
        if (arb.req0 | arb.req1) begin
          own_d   = sel;
          data_d  = sel ? arb.data1 : arb.data0;
          to_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // timer_q == 0 marks the first WAIT cycle, where eng_done may still be left over
        if ((timer_q != 8'd0) && arb.eng_done) begin
          crc_d   = arb.eng_crc[6:0];
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          crc_d   = 7'h7F;
          to_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        lp_d    = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb.busy      = (state_q != IDLE);
  assign arb.gnt0      = arb.busy & ~own_q;
  assign arb.gnt1      = arb.busy & own_q;
  assign arb.ack0      = (state_q == DONE) & ~own_q;
  assign arb.ack1      = (state_q == DONE) & own_q;
  assign arb.err       = (state_q == DONE) & to_q;
  assign arb.eng_start = (state_q == START);
  assign arb.eng_data  = data_q;
  assign arb.crc_out   = crc_q;
endmodule

// File: tb/tb_crc7_arbiter.sv
// Self-checking bench for crc7_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules, with a small engine model.
module tb_crc7_arbiter;
  localparam int TO = 64;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc7_arbiter_if bus();
  crc7_arbiter #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .arb(bus));

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: mode 0 raises done 3 cycles after start, 1 holds done high, 2 never finishes.
  int         eng_mode = 0;
  bit         use_fixed = 0;
  logic [7:0] fixed_crc = 8'h00;
  logic [1:0] eng_cnt;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      eng_cnt      <= 2'd0;
      bus.eng_done <= 1'b0;
      bus.eng_crc  <= 8'h00;
    end else begin
      if (bus.eng_start === 1'b1) bus.eng_crc <= use_fixed ? fixed_crc : 8'($urandom);
      case (eng_mode)
        1: bus.eng_done <= 1'b1;
        2: bus.eng_done <= 1'b0;
        default: begin
          if (bus.eng_start === 1'b1) begin
            eng_cnt      <= 2'd1;
            bus.eng_done <= 1'b0;
          end else if (eng_cnt == 2'd2) begin
            eng_cnt      <= 2'd0;
            bus.eng_done <= 1'b1;
          end else if (eng_cnt != 2'd0) begin
            eng_cnt <= eng_cnt + 2'd1;
          end
        end
      endcase
    end
  end

  // Event counters sampled on the falling edge
  int          n_start = 0, n_gnt1 = 0, n_ack0 = 0, n_ack1 = 0;
  int          both_gnt = 0, both_ack = 0, lone_err = 0;
  logic [31:0] start_data = 32'h0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.eng_start === 1'b1) begin
        n_start    <= n_start + 1;
        start_data <= bus.eng_data;
      end
      if (bus.gnt1 === 1'b1) n_gnt1 <= n_gnt1 + 1;
      if (bus.ack0 === 1'b1) n_ack0 <= n_ack0 + 1;
      if (bus.ack1 === 1'b1) n_ack1 <= n_ack1 + 1;
      if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) both_gnt <= both_gnt + 1;
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_ack <= both_ack + 1;
      if (bus.err === 1'b1 && bus.ack0 !== 1'b1 && bus.ack1 !== 1'b1) lone_err <= lone_err + 1;
    end
  end

  // Waits up to limit falling edges for an ack; idx=-1 when none arrived.
  task automatic wait_ack(input int limit, output int idx, output int at);
    idx = -1;
    at  = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        idx = (bus.ack1 === 1'b1) ? 1 : 0;
        at  = cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 32'h0; bus.data1 = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.busy, bus.eng_start} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.busy, bus.eng_start});
    end
    checks++;
    if (bus.eng_data !== 32'h0) begin
      errors++; $display("FAIL reset_eng_data got=%h exp=00000000", bus.eng_data);
    end
    checks++;
    if (bus.crc_out !== 7'h00) begin
      errors++; $display("FAIL reset_crc_out got=%h exp=00", bus.crc_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_req busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_single();
    int t0, idx, at, s0, g1;
    s0 = n_start; g1 = n_gnt1;
    use_fixed = 1; fixed_crc = 8'hA5; eng_mode = 0;
    bus.data0 = 32'h4000_0000; bus.req0 = 1'b1; t0 = cyc;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++; $display("FAIL single_gnt0 got=%b exp=1", bus.gnt0);
    end
    bus.req0 = 1'b0;
    wait_ack(30, idx, at);
    checks++;
    if (idx != 0 || at - t0 != 5) begin
      errors++; $display("FAIL single_ack idx=%0d lat=%0d exp idx=0 lat=5", idx, at - t0);
    end
    checks++;
    if (bus.crc_out !== 7'h25 || bus.err !== 1'b0) begin
      errors++; $display("FAIL single_crc got=%h err=%b exp=25 err=0", bus.crc_out, bus.err);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_start - s0 != 1 || start_data !== 32'h4000_0000) begin
      errors++; $display("FAIL single_start n=%0d data=%h exp n=1 data=40000000", n_start - s0, start_data);
    end
    checks++;
    if (n_gnt1 != g1) begin
      errors++; $display("FAIL single_gnt1 cycles got=%0d exp=0", n_gnt1 - g1);
    end
    use_fixed = 0;
  endtask

  task automatic test_contention();
    logic [31:0] d0, d1;
    int idx, at;
    d0 = $urandom; d1 = ~d0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.data0 = d0; bus.data1 = d1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(30, idx, at);
      checks++;
      if (idx != k % 2 || bus.eng_data !== ((k % 2) ? d1 : d0)) begin
        errors++;
        $display("FAIL contention_%0d idx=%0d data=%h exp idx=%0d data=%h", k, idx, bus.eng_data,
                 k % 2, (k % 2) ? d1 : d0);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drain();
  endtask

  task automatic test_stale_done();
    int t0, idx, at;
    eng_mode = 1;
    repeat (2) @(negedge clk);
    bus.data0 = $urandom; bus.req0 = 1'b1; t0 = cyc;
    @(negedge clk);
    bus.req0 = 1'b0;
    wait_ack(30, idx, at);
    checks++;
    if (idx != 0 || at - t0 != 4) begin
      errors++; $display("FAIL stale_done idx=%0d lat=%0d exp idx=0 lat=4", idx, at - t0);
    end
    eng_mode = 0;
    drain();
  endtask

  task automatic test_timeout();
    int t0, idx, at;
    eng_mode = 2;
    bus.data1 = $urandom; bus.req1 = 1'b1; t0 = cyc;
    @(negedge clk);
    bus.req1 = 1'b0;
    wait_ack(100, idx, at);
    checks++;
    if (idx != 1 || at - t0 != TO + 2) begin
      errors++; $display("FAIL timeout_ack idx=%0d lat=%0d exp idx=1 lat=%0d", idx, at - t0, TO + 2);
    end
    checks++;
    if (bus.err !== 1'b1 || bus.crc_out !== 7'h7F) begin
      errors++; $display("FAIL timeout_err err=%b crc=%h exp err=1 crc=7f", bus.err, bus.crc_out);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL timeout_idle busy=%b err=%b exp 0 0", bus.busy, bus.err);
    end
    eng_mode = 0;
    drain();
  endtask

  task automatic test_reset_mid_wait();
    int idx, at;
    bus.data1 = $urandom; bus.req1 = 1'b1;
    @(negedge clk);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.busy, bus.eng_start} !== 7'b0 ||
        bus.eng_data !== 32'h0 || bus.crc_out !== 7'h00) begin
      errors++;
      $display("FAIL midreset_outputs ctrl=%b data=%h crc=%h exp all zero",
               {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err, bus.busy, bus.eng_start},
               bus.eng_data, bus.crc_out);
    end
    rst = 1'b0;
    bus.data0 = $urandom; bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++; $display("FAIL midreset_first_gnt gnt0=%b gnt1=%b exp 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 1'b0;
    wait_ack(30, idx, at);
    checks++;
    if (idx != 0) begin
      errors++; $display("FAIL midreset_first_ack idx=%0d exp=0", idx);
    end
    wait_ack(30, idx, at);
    bus.req1 = 1'b0;
    checks++;
    if (idx != 1) begin
      errors++; $display("FAIL midreset_second_ack idx=%0d exp=1", idx);
    end
    drain();
  endtask

  task automatic test_early_release();
    logic [31:0] a;
    int idx, at;
    a = $urandom;
    bus.data0 = a; bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0; bus.data0 = ~a;
    @(negedge clk);
    checks++;
    if (bus.eng_data !== a) begin
      errors++; $display("FAIL early_latched got=%h exp=%h", bus.eng_data, a);
    end
    wait_ack(30, idx, at);
    checks++;
    if (idx != 0 || bus.eng_data !== a) begin
      errors++; $display("FAIL early_ack idx=%0d data=%h exp idx=0 data=%h", idx, bus.eng_data, a);
    end
    drain();
  endtask

  // Randomized requesters checked against the arbitration rules at transaction level.
  task automatic test_random();
    bit          pend [2];
    logic [31:0] jd [2];
    bit          free_m, busy_m, free_pend, dec_valid;
    int          own_m, lp_m, idx, nacks;
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; eng_mode = 0; use_fixed = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    free_m = 1; busy_m = 0; free_pend = 0; dec_valid = 0;
    lp_m = 1; own_m = 0; nacks = 0;
    pend[0] = 0; pend[1] = 0; jd[0] = 32'h0; jd[1] = 32'h0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (dec_valid) begin
        checks++;
        if ({bus.gnt1, bus.gnt0} !== ((own_m == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rand_gnt c=%0d got=%b exp_owner=%0d", c, {bus.gnt1, bus.gnt0}, own_m);
        end
        dec_valid = 0;
      end
      if (free_pend) begin
        free_m = 1; free_pend = 0;
      end
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        idx = (bus.ack1 === 1'b1) ? 1 : 0;
        checks++;
        if (!busy_m || idx != own_m) begin
          errors++; $display("FAIL rand_ack c=%0d idx=%0d exp=%0d busy_m=%0d", c, idx, own_m, busy_m);
        end
        checks++;
        if (bus.crc_out !== bus.eng_crc[6:0] || bus.err !== 1'b0) begin
          errors++; $display("FAIL rand_crc c=%0d got=%h err=%b exp=%h err=0", c, bus.crc_out, bus.err,
                             bus.eng_crc[6:0]);
        end
        checks++;
        if (bus.eng_data !== jd[idx]) begin
          errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus.eng_data, jd[idx]);
        end
        pend[idx] = 0;
        lp_m = own_m; busy_m = 0; free_pend = 1; nacks++;
      end
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          jd[k] = $urandom;
          if (c < 800 && $urandom_range(3) == 0) pend[k] = 1;
        end
      end
      bus.req0 = pend[0]; bus.req1 = pend[1];
      bus.data0 = jd[0]; bus.data1 = jd[1];
      if (free_m && (pend[0] || pend[1])) begin
        own_m = (pend[0] && pend[1]) ? 1 - lp_m : (pend[1] ? 1 : 0);
        free_m = 0; busy_m = 1; dec_valid = 1;
      end
    end
    checks++;
    if (pend[0] || pend[1] || nacks < 20) begin
      errors++; $display("FAIL rand_complete pend=%0d%0d acks=%0d exp pend=00 acks>=20", pend[0], pend[1], nacks);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drain();
  endtask

  task automatic test_invariants();
    checks++;
    if (both_gnt != 0 || both_ack != 0 || lone_err != 0) begin
      errors++; $display("FAIL invariants both_gnt=%0d both_ack=%0d lone_err=%0d exp 0 0 0",
                         both_gnt, both_ack, lone_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 32'h0; bus.data1 = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_stale_done();
    test_timeout();
    test_reset_mid_wait();
    test_early_release();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
